if_fetch_unit: RTL and testbench

- IF-stage block that consumes the next-PC / redirect from the NPC selection logic.
- Owns PCF and issues in-order word fetches to instruction memory over a req/gnt/rvalid handshake.
- Buffers returned instructions in a small FIFO and presents them to the ID stage as InstrD/PCD/ValidD.
- After a redirect, discards every response still in flight.

---
 rtl/if_pkg.sv | 12 +
 rtl/fetch_fifo.sv | 68 ++++++
 rtl/if_fetch_unit.sv | 132 +++++++++++++
 tb/tb_if_fetch_unit.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch_entry_t with a synchronous clear.
// Serves both as the instruction buffer and as the in-order PC tag queue.
module fetch_fifo
    import if_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 2
) (
    input  logic             CPU_CLK,
    input  logic             CPU_RST,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  fetch_entry_t     din,
    output logic [CNT_W-1:0] occupancy,
    output fetch_entry_t     head
);

    localparam int               PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_pop;
    logic             do_push;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // A push into a full FIFO is accepted only when a pop frees the slot in the same cycle.
    assign do_pop  = pop && (occupancy != '0);
    assign do_push = push && ((occupancy != FULL) || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge CPU_CLK) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge CPU_CLK or posedge CPU_RST) begin
        if (CPU_RST) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            occupancy <= '0;
        end else if (clear) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            if (do_push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   occupancy <= occupancy + CNT_W'(1);
                2'b01:   occupancy <= occupancy - CNT_W'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// IF stage: owns PCF, issues credit-limited in-order fetches and buffers responses for ID.
// Optional same-cycle response bypass to ID when IF_FETCH_BYPASS_EN is defined.
module if_fetch_unit
    import if_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int              FIFO_DEPTH = 2,
    parameter int              CNT_W      = 2
) (
    input  logic            CPU_CLK,
    input  logic            CPU_RST,
    input  logic            RedirectValid,
    input  logic [XLEN-1:0] RedirectPC,
    input  logic            StallD,
    output logic            ImemReq,
    output logic [XLEN-1:0] ImemAddr,
    input  logic            ImemGnt,
    input  logic            ImemRvalid,
    input  logic [XLEN-1:0] ImemRdata,
    output logic            ValidD,
    output logic [XLEN-1:0] InstrD,
    output logic [XLEN-1:0] PCD
);

    // Memory handshake: a request transfers when ImemReq & ImemGnt; ImemAddr is held while
    // ImemReq waits for ImemGnt; each ImemRvalid returns exactly one word, in request order.

    localparam int SUM_W = CNT_W + 1;

    logic [XLEN-1:0]  pcf;
    logic [CNT_W-1:0] occ;
    logic [CNT_W-1:0] tag_occ;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] drop_cnt;
    logic [SUM_W-1:0] credit_used;
    fetch_entry_t     fifo_head;
    fetch_entry_t     fifo_din;
    fetch_entry_t     tag_head;
    fetch_entry_t     tag_din;
    logic             grant;
    logic             resp_keep;
    logic             bypass;
    logic             fifo_push;
    logic             fifo_pop;
    logic             unused_ok;

    assign credit_used = {1'b0, occ} + {1'b0, outstanding};
    assign ImemReq     = !CPU_RST && !RedirectValid && (credit_used < SUM_W'(FIFO_DEPTH));
    assign ImemAddr    = pcf;
    assign grant       = ImemReq && ImemGnt;

    // A response is kept only when no redirect kills it and nothing older still needs dropping.
    assign resp_keep = ImemRvalid && !RedirectValid && (drop_cnt == '0);
`ifdef IF_FETCH_BYPASS_EN
    assign bypass = resp_keep && (occ == '0) && !StallD;
`else
    assign bypass = 1'b0;
`endif
    assign fifo_push = resp_keep && !bypass;
    assign fifo_pop  = (occ != '0) && !StallD && !RedirectValid;

    assign tag_din  = '{pc: pcf, instr: '0};
    assign fifo_din = '{pc: tag_head.pc, instr: ImemRdata};

    always_comb begin
        ValidD = 1'b0;
        InstrD = NOP_INSTR;
        PCD    = '0;
        if (occ != '0) begin
            ValidD = 1'b1;
            InstrD = fifo_head.instr;
            PCD    = fifo_head.pc;
        end else if (bypass) begin
            ValidD = 1'b1;
            InstrD = ImemRdata;
            PCD    = tag_head.pc;
        end
    end

    always_ff @(posedge CPU_CLK or posedge CPU_RST) begin
        if (CPU_RST) begin
            pcf         <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding + CNT_W'(grant) - CNT_W'(ImemRvalid);
            if (RedirectValid) begin
                pcf      <= {RedirectPC[XLEN-1:2], 2'b00};
                // Everything still in flight after this cycle's response belongs to the old path.
                drop_cnt <= outstanding - CNT_W'(ImemRvalid);
            end else begin
                if (grant) begin
                    pcf <= pcf + XLEN'(4);
                end
                if (ImemRvalid && (drop_cnt != '0)) begin
                    drop_cnt <= drop_cnt - CNT_W'(1);
                end
            end
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_tag_q (
        .CPU_CLK   (CPU_CLK),
        .CPU_RST   (CPU_RST),
        .push      (grant),
        .pop       (ImemRvalid),
        .clear     (1'b0),
        .din       (tag_din),
        .occupancy (tag_occ),
        .head      (tag_head)
    );

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_instr_q (
        .CPU_CLK   (CPU_CLK),
        .CPU_RST   (CPU_RST),
        .push      (fifo_push),
        .pop       (fifo_pop),
        .clear     (RedirectValid),
        .din       (fifo_din),
        .occupancy (occ),
        .head      (fifo_head)
    );

    assign unused_ok = ^{tag_head.instr, tag_occ, RedirectPC[1:0]};

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: queue-based reference model, directed scenarios and random traffic.
module tb_if_fetch_unit;

    localparam int          DEPTH = 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] SALT  = 32'hA5A5_A5A5;

    logic        CPU_CLK = 1'b0;
    logic        CPU_RST = 1'b1;
    logic        RedirectValid = 1'b0;
    logic [31:0] RedirectPC = '0;
    logic        StallD = 1'b0;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic        ImemGnt = 1'b0;
    logic        ImemRvalid = 1'b0;
    logic [31:0] ImemRdata = '0;
    logic        ValidD;
    logic [31:0] InstrD;
    logic [31:0] PCD;

    if_fetch_unit dut (
        .CPU_CLK       (CPU_CLK),
        .CPU_RST       (CPU_RST),
        .RedirectValid (RedirectValid),
        .RedirectPC    (RedirectPC),
        .StallD        (StallD),
        .ImemReq       (ImemReq),
        .ImemAddr      (ImemAddr),
        .ImemGnt       (ImemGnt),
        .ImemRvalid    (ImemRvalid),
        .ImemRdata     (ImemRdata),
        .ValidD        (ValidD),
        .InstrD        (InstrD),
        .PCD           (PCD)
    );

    always #5 CPU_CLK = ~CPU_CLK;

    int assertions = 0;
    int failures   = 0;

    // Reference model state: fetch PC, PCs in flight, buffered entries, responses still to drop.
    logic [31:0] pcf_m;
    logic [31:0] tag_m[$];
    logic [31:0] fifo_pc[$];
    logic [31:0] fifo_in[$];
    int          drop_m;

    // Memory environment: data words owed for granted requests, in order.
    logic [31:0] mem_q[$];
    bit          directed_data;

    logic [31:0] got_addr[$];
    logic [31:0] got_pc[$];
    logic [31:0] got_instr[$];
    logic        last_req;
    logic        last_valid;
    logic [31:0] last_addr;
    logic [31:0] last_pcd;
    logic [31:0] last_instr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertions++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        pcf_m  = 32'h0;
        drop_m = 0;
        tag_m.delete();
        fifo_pc.delete();
        fifo_in.delete();
        mem_q.delete();
    endtask

    task automatic do_reset();
        @(negedge CPU_CLK);
        CPU_RST       = 1'b1;
        RedirectValid = 1'b0;
        RedirectPC    = '0;
        StallD        = 1'b0;
        ImemGnt       = 1'b0;
        ImemRvalid    = 1'b0;
        ImemRdata     = '0;
        #1;
        check("rst_req",   32'(ImemReq), 32'd0);
        check("rst_addr",  ImemAddr,     32'h0);
        check("rst_valid", 32'(ValidD),  32'd0);
        check("rst_instr", InstrD,       NOP);
        check("rst_pcd",   PCD,          32'h0);
        model_reset();
        @(negedge CPU_CLK);
        CPU_RST = 1'b0;
    endtask

    task automatic step(input logic redir, input logic [31:0] rpc, input logic stall,
                        input logic gnt, input logic want_rv);
        logic        exp_req;
        logic        exp_valid;
        logic        byp;
        logic        granted;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
        logic [31:0] rtag;
        logic [31:0] gaddr;
        @(negedge CPU_CLK);
        RedirectValid = redir;
        RedirectPC    = rpc;
        StallD        = stall;
        ImemGnt       = gnt;
        ImemRvalid    = want_rv && (mem_q.size() > 0);
        ImemRdata     = ImemRvalid ? mem_q[0] : $urandom;
        #1;
        exp_req = !redir && ((fifo_pc.size() + tag_m.size()) < DEPTH);
        byp     = 1'b0;
`ifdef IF_FETCH_BYPASS_EN
        byp = ImemRvalid && !redir && (drop_m == 0) && (fifo_pc.size() == 0) && !stall;
`endif
        if (fifo_pc.size() > 0) begin
            exp_valid = 1'b1;
            exp_pc    = fifo_pc[0];
            exp_instr = fifo_in[0];
        end else if (byp) begin
            exp_valid = 1'b1;
            exp_pc    = tag_m[0];
            exp_instr = ImemRdata;
        end else begin
            exp_valid = 1'b0;
            exp_pc    = 32'h0;
            exp_instr = NOP;
        end
        check("ImemReq",  32'(ImemReq), 32'(exp_req));
        check("ImemAddr", ImemAddr,     pcf_m);
        check("ValidD",   32'(ValidD),  32'(exp_valid));
        check("InstrD",   InstrD,       exp_instr);
        check("PCD",      PCD,          exp_pc);
        last_req   = ImemReq;
        last_addr  = ImemAddr;
        last_valid = ValidD;
        last_pcd   = PCD;
        last_instr = InstrD;
        granted    = exp_req && gnt;
        gaddr      = ImemAddr;
        if (granted) got_addr.push_back(ImemAddr);
        if (exp_valid && !stall && !redir) begin
            got_pc.push_back(PCD);
            got_instr.push_back(InstrD);
        end
        @(posedge CPU_CLK);
        rtag = 32'h0;
        if (ImemRvalid) begin
            void'(mem_q.pop_front());
            rtag = tag_m.pop_front();
        end
        if (redir) begin
            fifo_pc.delete();
            fifo_in.delete();
            drop_m = tag_m.size();
            pcf_m  = {rpc[31:2], 2'b00};
        end else begin
            if ((fifo_pc.size() > 0) && !stall) begin
                void'(fifo_pc.pop_front());
                void'(fifo_in.pop_front());
            end
            if (ImemRvalid) begin
                if (drop_m > 0) begin
                    drop_m--;
                end else if (!byp) begin
                    fifo_pc.push_back(rtag);
                    fifo_in.push_back(ImemRdata);
                end
            end
            if (granted) begin
                tag_m.push_back(pcf_m);
                mem_q.push_back(directed_data ? (gaddr ^ SALT) : $urandom);
                pcf_m = pcf_m + 32'd4;
            end
        end
    endtask

    function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
        return (q.size() > i) ? q[i] : 32'hDEAD_BEEF;
    endfunction

    initial begin
        directed_data = 1'b1;
        model_reset();
        do_reset();

        // Steady streaming from reset.
        got_addr.delete();
        got_pc.delete();
        got_instr.delete();
        repeat (10) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        check("seq_addr0",  qget(got_addr, 0),  32'h0000_0000);
        check("seq_addr1",  qget(got_addr, 1),  32'h0000_0004);
        check("seq_addr2",  qget(got_addr, 2),  32'h0000_0008);
        check("seq_pc0",    qget(got_pc, 0),    32'h0000_0000);
        check("seq_pc1",    qget(got_pc, 1),    32'h0000_0004);
        check("seq_pc2",    qget(got_pc, 2),    32'h0000_0008);
        check("seq_instr0", qget(got_instr, 0), 32'hA5A5_A5A5);
        check("seq_instr1", qget(got_instr, 1), 32'hA5A5_A5A1);
        check("seq_instr2", qget(got_instr, 2), 32'hA5A5_A5AD);

        // Stall: credits exhaust and the head holds.
        repeat (5) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        check("stall_req_off", 32'(last_req),   32'd0);
        check("stall_valid",   32'(last_valid), 32'd1);
        repeat (6) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);

        // Redirect with two responses in flight.
        do_reset();
        repeat (3) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        check("two_out_req_off", 32'(last_req), 32'd0);
        step(1'b1, 32'h0000_0100, 1'b0, 1'b1, 1'b0);
        check("redir_req_off", 32'(last_req), 32'd0);
        got_pc.delete();
        repeat (8) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        check("redir_first_pc", qget(got_pc, 0), 32'h0000_0100);

        // Misaligned redirect target.
        step(1'b1, 32'h0000_0203, 1'b0, 1'b1, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        check("redir_align", last_addr, 32'h0000_0200);

        // PC wrap at the top of the address space.
        repeat (6) step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        check("wrap_top_addr", last_addr, 32'hFFFF_FFFC);
        check("wrap_top_req",  32'(last_req), 32'd1);
        repeat (4) step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        check("wrap_addr", last_addr, 32'h0);
        check("gnt_low_req_held", 32'(last_req), 32'd1);

        // Response latency into an empty buffer.
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
`ifdef IF_FETCH_BYPASS_EN
        check("lat0_valid", 32'(last_valid), 32'd1);
        check("lat0_pcd",   last_pcd,        32'hFFFF_FFFC);
        check("lat0_instr", last_instr,      32'h5A5A_5A59);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        check("lat1_valid", 32'(last_valid), 32'd0);
`else
        check("lat0_valid", 32'(last_valid), 32'd0);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        check("lat1_valid", 32'(last_valid), 32'd1);
        check("lat1_pcd",   last_pcd,        32'hFFFF_FFFC);
        check("lat1_instr", last_instr,      32'h5A5A_5A59);
`endif

        // Random traffic with one reset in the middle.
        directed_data = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (i == 2000) do_reset();
            step(($urandom_range(0, 15) == 0), $urandom, ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
